// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared access type, direction and responder state encodings for the memory handshake
package arm_mem_pkg;
  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/ram_handshake_responder.sv
// ram_handshake_responder: big-endian byte RAM served over MFA/MFC (in: CLK CLR_N MFA RW_RAM TYPE ADDR DATA_IN; out: DATA_OUT MFC)
module ram_handshake_responder
  import arm_mem_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 256
) (
  input  logic        CLK,
  input  logic        CLR_N,
  input  logic        MFA,
  input  logic        RW_RAM,
  input  logic [1:0]  TYPE,
  input  logic [7:0]  ADDR,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  output logic        MFC
);
  logic [7:0] Mem [0:DEPTH-1];
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic [7:0] r_addr;
  logic r_rw;
  logic [1:0] r_type;
  logic [31:0] r_din;
  logic w_start, w_go;
  logic [7:0] w_aligned, w_a1, w_a2, w_a3;
  logic [31:0] w_rdata;
  assign w_start = r_state == IDLE && MFA;
  assign w_go = r_state == BUSY && MFA && r_cnt == 4'd0;
  assign w_aligned = TYPE == BYTE ? ADDR : TYPE == HALF ? {ADDR[7:1], 1'b0} : {ADDR[7:2], 2'b00};
  assign w_a1 = r_addr + 8'd1;
  assign w_a2 = r_addr + 8'd2;
  assign w_a3 = r_addr + 8'd3;
  assign w_rdata = r_type == BYTE ? {24'h0, Mem[r_addr]}
                 : r_type == HALF ? {16'h0, Mem[r_addr], Mem[w_a1]}
                 : {Mem[r_addr], Mem[w_a1], Mem[w_a2], Mem[w_a3]};
  assign MFC = r_state == DONE;
  always_ff @(posedge CLK or negedge CLR_N)
    if (!CLR_N) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = MFA ? BUSY : IDLE;
    else if (r_state == BUSY) w_next = !MFA ? IDLE : (r_cnt == 4'd0 ? DONE : BUSY);
    else w_next = MFA ? DONE : IDLE;
  end
  always_ff @(posedge CLK or negedge CLR_N)
    if (!CLR_N) begin
      r_cnt <= 4'd0;
      r_addr <= 8'h0;
      r_rw <= READ;
      r_type <= BYTE;
      r_din <= 32'h0;
      DATA_OUT <= 32'h0;
    end else begin
      if (w_start) begin
        r_cnt <= 4'(LATENCY - 1);
        r_addr <= w_aligned;
        r_rw <= RW_RAM;
        r_type <= TYPE;
        r_din <= DATA_IN;
      end else if (r_state == BUSY && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_go && r_rw == READ) DATA_OUT <= w_rdata;
    end
  // Storage has no reset so it survives CLR_N and can be preloaded hierarchically.
  always_ff @(posedge CLK)
    if (w_go && r_rw == WRITE) begin
      if (r_type == BYTE) Mem[r_addr] <= r_din[7:0];
      else if (r_type == HALF) begin
        Mem[r_addr] <= r_din[15:8];
        Mem[w_a1] <= r_din[7:0];
      end else begin
        Mem[r_addr] <= r_din[31:24];
        Mem[w_a1] <= r_din[23:16];
        Mem[w_a2] <= r_din[15:8];
        Mem[w_a3] <= r_din[7:0];
      end
    end
endmodule

// File: tb/tb_ram_handshake_responder.sv
// tb_ram_handshake_responder: directed checks of the MFA/MFC RAM responder at LATENCY 2 and 1
module tb_ram_handshake_responder;
  logic clk = 1'b0, clr_n = 1'b0, mfa = 1'b0, mfa1 = 1'b0, rw = 1'b1;
  logic [1:0] ty = 2'b00;
  logic [7:0] addr = 8'h0;
  logic [31:0] din = 32'h0, dout, dout1;
  logic mfc, mfc1;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  ram_handshake_responder #(.LATENCY(2)) dut (.CLK(clk), .CLR_N(clr_n), .MFA(mfa), .RW_RAM(rw), .TYPE(ty),
    .ADDR(addr), .DATA_IN(din), .DATA_OUT(dout), .MFC(mfc));
  ram_handshake_responder #(.LATENCY(1)) dut1 (.CLK(clk), .CLR_N(clr_n), .MFA(mfa1), .RW_RAM(rw), .TYPE(ty),
    .ADDR(addr), .DATA_IN(din), .DATA_OUT(dout1), .MFC(mfc1));
  function automatic logic [7:0] pre(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction
  task automatic access(input bit d1, input logic r, input logic [1:0] t, input logic [7:0] a,
                        input logic [31:0] d, output int edges, output logic [31:0] q);
    @(negedge clk);
    rw = r; ty = t; addr = a; din = d;
    if (d1) mfa1 = 1'b1; else mfa = 1'b1;
    @(posedge clk); #1;
    edges = 0;
    while (!(d1 ? mfc1 : mfc) && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    q = d1 ? dout1 : dout;
    @(negedge clk);
    mfa = 1'b0; mfa1 = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    n_chk++; if (mfc !== 1'b0) begin n_fail++; $display("FAIL reset_mfc: got %b expected 0", mfc); end
    n_chk++; if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 00000000", dout); end
    n_chk++; if (mfc1 !== 1'b0) begin n_fail++; $display("FAIL reset_mfc1: got %b expected 0", mfc1); end
    n_chk++; if (dout1 !== 32'h0) begin n_fail++; $display("FAIL reset_dout1: got %h expected 00000000", dout1); end
    @(negedge clk); clr_n = 1'b1;
  endtask
  task automatic test_word_read;
    int e; logic [31:0] q;
    access(0, 1'b1, 2'b10, 8'h0A, 32'h0, e, q);
    n_chk++; if (e !== 2) begin n_fail++; $display("FAIL word_read_latency: got %0d expected 2", e); end
    n_chk++; if (q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_read_data: got %h expected deadbeef", q); end
    n_chk++; if (mfc !== 1'b0) begin n_fail++; $display("FAIL word_read_mfc_fall: got %b expected 0", mfc); end
  endtask
  task automatic test_reset_mid;
    int e; logic [31:0] q;
    @(negedge clk);
    rw = 1'b0; ty = 2'b10; addr = 8'h30; din = 32'hCAFEF00D; mfa = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); clr_n = 1'b0; #1;
    n_chk++; if (mfc !== 1'b0) begin n_fail++; $display("FAIL midreset_mfc: got %b expected 0", mfc); end
    n_chk++; if (dout !== 32'h0) begin n_fail++; $display("FAIL midreset_dout: got %h expected 00000000", dout); end
    mfa = 1'b0;
    @(negedge clk); clr_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (dut.Mem[8'h30] !== pre(8'h30) || dut.Mem[8'h33] !== pre(8'h33)) begin
      n_fail++; $display("FAIL midreset_nowrite: got %h..%h expected %h..%h", dut.Mem[8'h30], dut.Mem[8'h33], pre(8'h30), pre(8'h33));
    end
    access(0, 1'b1, 2'b10, 8'h08, 32'h0, e, q);
    n_chk++; if (e !== 2) begin n_fail++; $display("FAIL midreset_next_latency: got %0d expected 2", e); end
    n_chk++; if (q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL midreset_next_data: got %h expected deadbeef", q); end
  endtask
  task automatic test_byte_half;
    int e; logic [31:0] q;
    access(0, 1'b0, 2'b00, 8'h13, 32'hFFFFFF5A, e, q);
    n_chk++; if (e !== 2) begin n_fail++; $display("FAIL byte_write_latency: got %0d expected 2", e); end
    n_chk++; if (dut.Mem[8'h13] !== 8'h5A) begin n_fail++; $display("FAIL byte_write_mem: got %h expected 5a", dut.Mem[8'h13]); end
    n_chk++; if (dut.Mem[8'h12] !== pre(8'h12)) begin n_fail++; $display("FAIL byte_write_lo_nbr: got %h expected %h", dut.Mem[8'h12], pre(8'h12)); end
    n_chk++; if (dut.Mem[8'h14] !== pre(8'h14)) begin n_fail++; $display("FAIL byte_write_hi_nbr: got %h expected %h", dut.Mem[8'h14], pre(8'h14)); end
    n_chk++; if (dout !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_keeps_dout: got %h expected deadbeef", dout); end
    access(0, 1'b1, 2'b01, 8'h12, 32'h0, e, q);
    n_chk++; if (q !== {16'h0, pre(8'h12), 8'h5A}) begin n_fail++; $display("FAIL half_read: got %h expected %h", q, {16'h0, pre(8'h12), 8'h5A}); end
    access(0, 1'b1, 2'b01, 8'h13, 32'h0, e, q);
    n_chk++; if (q !== {16'h0, pre(8'h12), 8'h5A}) begin n_fail++; $display("FAIL half_read_align: got %h expected %h", q, {16'h0, pre(8'h12), 8'h5A}); end
    access(0, 1'b1, 2'b00, 8'h13, 32'h0, e, q);
    n_chk++; if (q !== 32'h0000005A) begin n_fail++; $display("FAIL byte_read: got %h expected 0000005a", q); end
    access(0, 1'b0, 2'b01, 8'h41, 32'h0000BEEF, e, q);
    n_chk++; if (dut.Mem[8'h40] !== 8'hBE || dut.Mem[8'h41] !== 8'hEF || dut.Mem[8'h42] !== pre(8'h42)) begin
      n_fail++; $display("FAIL half_write: got %h %h %h expected be ef %h", dut.Mem[8'h40], dut.Mem[8'h41], dut.Mem[8'h42], pre(8'h42));
    end
  endtask
  task automatic test_abort;
    int rose = 0;
    logic [31:0] q;
    q = dout;
    @(negedge clk);
    rw = 1'b0; ty = 2'b10; addr = 8'h20; din = 32'h11223344; mfa = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); mfa = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (mfc !== 1'b0) rose++;
    end
    n_chk++; if (rose !== 0) begin n_fail++; $display("FAIL abort_mfc: got %0d cycles high expected 0", rose); end
    n_chk++; if ({dut.Mem[8'h20], dut.Mem[8'h21], dut.Mem[8'h22], dut.Mem[8'h23]} !== {pre(8'h20), pre(8'h21), pre(8'h22), pre(8'h23)}) begin
      n_fail++; $display("FAIL abort_mem: got %h%h%h%h expected %h%h%h%h", dut.Mem[8'h20], dut.Mem[8'h21], dut.Mem[8'h22], dut.Mem[8'h23],
        pre(8'h20), pre(8'h21), pre(8'h22), pre(8'h23));
    end
    n_chk++; if (dout !== q) begin n_fail++; $display("FAIL abort_dout: got %h expected %h", dout, q); end
  endtask
  task automatic test_hold;
    int e = 0, lo = 0;
    @(negedge clk);
    rw = 1'b1; ty = 2'b10; addr = 8'h09; mfa = 1'b1;
    @(posedge clk); #1;
    rw = 1'b0; ty = 2'b00; addr = 8'h20; din = 32'h0;
    while (!mfc && e < 20) begin
      @(posedge clk); #1;
      e++;
    end
    n_chk++; if (e !== 2) begin n_fail++; $display("FAIL hold_latency: got %0d expected 2", e); end
    repeat (5) begin
      @(posedge clk); #1;
      n_chk++; if (mfc !== 1'b1) begin n_fail++; $display("FAIL hold_mfc: got %b expected 1", mfc); end
      n_chk++; if (dout !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold_dout: got %h expected deadbeef", dout); end
    end
    @(negedge clk); mfa = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (mfc !== 1'b0) begin n_fail++; $display("FAIL hold_mfc_fall: got %b expected 0", mfc); end
    repeat (3) begin
      @(posedge clk); #1;
      if (mfc !== 1'b0) lo++;
    end
    n_chk++; if (lo !== 0 || dut.Mem[8'h20] !== pre(8'h20)) begin
      n_fail++; $display("FAIL hold_no_second: got %0d mfc-high cycles mem %h expected 0 and %h", lo, dut.Mem[8'h20], pre(8'h20));
    end
  endtask
  task automatic test_latency1;
    int e; logic [31:0] q;
    access(1, 1'b0, 2'b10, 8'hFC, 32'h12345678, e, q);
    n_chk++; if (e !== 1) begin n_fail++; $display("FAIL lat1_write_latency: got %0d expected 1", e); end
    n_chk++; if (dut1.Mem[8'hFC] !== 8'h12 || dut1.Mem[8'hFF] !== 8'h78) begin
      n_fail++; $display("FAIL lat1_write_mem: got %h..%h expected 12..78", dut1.Mem[8'hFC], dut1.Mem[8'hFF]);
    end
    access(1, 1'b1, 2'b10, 8'hFF, 32'h0, e, q);
    n_chk++; if (e !== 1) begin n_fail++; $display("FAIL lat1_read_latency: got %0d expected 1", e); end
    n_chk++; if (q !== 32'h12345678) begin n_fail++; $display("FAIL lat1_read_data: got %h expected 12345678", q); end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      dut.Mem[i] = pre(8'(i));
      dut1.Mem[i] = 8'h00;
    end
    dut.Mem[8] = 8'hDE; dut.Mem[9] = 8'hAD; dut.Mem[10] = 8'hBE; dut.Mem[11] = 8'hEF;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_word_read();
    test_reset_mid();
    test_byte_half();
    test_abort();
    test_hold();
    test_latency1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_handshake_responder.md
# ram_handshake_responder

Memory-side responder for the datapath's MFA/MFC memory handshake. It holds the 256-byte big-endian RAM and serves byte, halfword and word reads and writes. Each access completes after a configurable latency, and the block returns MFC to the control unit when the access is done. It sits between the datapath's MAR/MDR and the control unit.

## Interface
Parameters:
- LATENCY, 2: cycles from MFA sampled high to MFC asserted; legal range 1–15.
- DEPTH, 256: bytes of storage; 8-bit address.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- CLR_N  in  1  reset, asynchronous, active-low.
- MFA  in  1  memory function activate; initiator holds it high until MFC.
- RW_RAM  in  1  1 = read, 0 = write.
- TYPE  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- ADDR  in  8  byte address.
- DATA_IN  in  32  write data; byte in [7:0], halfword in [15:0].
- DATA_OUT  out  32  read data; zero-extended for byte/halfword.
- MFC  out  1  memory function complete.

## Operation
- Storage: byte array Mem[0:DEPTH-1], big-endian. Word at A: Mem[A] = [31:24] … Mem[A+3] = [7:0].
- Storage is not cleared by reset.
- Alignment: the address is forced aligned before use.
  - Halfword: ADDR[0] ignored.
  - Word: ADDR[1:0] ignored.
  - No wrap past 0xFF is possible.
- IDLE (reset state):
  - MFA sampled high → latch ADDR, RW_RAM, TYPE, DATA_IN.
  - Load counter with LATENCY-1 and go to BUSY.
  - Inputs are not sampled again until the next request.
- BUSY:
  - If MFA is sampled low → abort: go to IDLE, no write, DATA_OUT unchanged.
  - Otherwise, if counter = 0 → perform the access and go to DONE.
  - Otherwise → decrement the counter.
- Access:
  - Write updates only the bytes selected by TYPE.
  - Read loads DATA_OUT, with upper bytes zero.
  - Write leaves DATA_OUT unchanged.
- DONE:
  - MFC = 1; DATA_OUT held stable.
  - MFA sampled low → go to IDLE.
- Reset mid-operation: state returns to IDLE, MFC = 0, DATA_OUT = 0; a pending write is dropped.
- Reset values: MFC = 0, DATA_OUT = 32'h0, state IDLE, counter 0.

## Timing
- Let MFA be sampled high at edge e0.
  - MFC rises after edge e(LATENCY).
  - For a read, DATA_OUT is valid on that same edge.
  - For a write, memory is updated on that edge.
- MFC falls after the first edge at which MFA is sampled low in DONE.
- Minimum one IDLE cycle between requests. Holding MFA high continuously does not start a second access: a new request needs MFA low, then high.
- Input changes after e0 have no effect on the access in progress.
- Hierarchical preload of Mem by testbenches at time 0 must work: Mem is a plain reg array with no initial block.

## Structure
- Shared package `arm_mem_pkg`:
  - TYPE encodings BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10.
  - RW constants READ = 1'b1, WRITE = 1'b0.
  - Responder state encoding IDLE/BUSY/DONE.
- No sub-module. FSM, latency counter and byte-lane mux stay inline.

## Test plan
- Reset: CLR_N low mid-BUSY → MFC = 0, DATA_OUT = 0 immediately; next request behaves normally.
- Word read, LATENCY = 2:
  - Preload Mem[8..11] = DE AD BE EF; MFA = 1, RW_RAM = 1, TYPE = 10, ADDR = 8'h0A.
  - Expect MFC after 2 edges and DATA_OUT = 32'hDEADBEEF (address aligned to 8).
- Byte and halfword:
  - Write byte 8'h5A at 8'h13 → Mem[0x13] = 5A, neighbours unchanged.
  - Read halfword at 8'h12 → DATA_OUT = 32'h0000xx5A, where xx is the preloaded Mem[0x12].
- Abort: drop MFA one cycle after a word write to 8'h20 → MFC never rises; Mem[0x20..0x23] unchanged.
- Handshake hold: keep MFA high 5 cycles in DONE → MFC stays 1 and DATA_OUT stable; MFC falls one edge after MFA drops; no second access.
- LATENCY = 1 build: word write then read of 32'h12345678 at 8'hFC → MFC one edge after each request; readback matches.
